// File: rtl/terminal_hex_writer_if.sv
// Request bus between a field-write producer (debugger) and terminal_hex_writer.
// The producer drives the field description and requestValid; the writer answers
// with requestReady, which only reflects free space in its request queue.
interface terminal_hex_writer_if;
    logic        requestValid;
    logic        requestReady;
    logic [4:0]  requestRow;
    logic [6:0]  requestColumn;
    logic [31:0] requestValue;
    logic [3:0]  requestDigits;

    modport master (
        output requestValid,
        output requestRow,
        output requestColumn,
        output requestValue,
        output requestDigits,
        input  requestReady
    );

    modport slave (
        input  requestValid,
        input  requestRow,
        input  requestColumn,
        input  requestValue,
        input  requestDigits,
        output requestReady
    );
endinterface

// File: rtl/terminal_hex_writer.sv
// terminal_hex_writer: turns queued "print this value as hex at row/column"
// requests into single-character writes on the terminal text buffer port,
// one ASCII character per clock, most significant digit first.
// Requests aimed at a row past the bottom of the screen are counted and dropped.
// Characters that would fall past the end of their row are not written (no wrap),
// but still take their cycle so field timing never depends on the column.
// Optional build macro TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN: leading zero digits
// are printed as spaces; the last digit is always a real hex digit.
module terminal_hex_writer #(
    parameter int COLUMNS    = 80,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    terminal_hex_writer_if.slave  request,
    output logic [11:0]           terminalAddress,
    output logic                  shouldWriteTerminal,
    output logic [7:0]            terminalWriteData,
    output logic                  busy,
    output logic [7:0]            droppedCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // One queued field: base address already resolved, column kept for the
    // end-of-row test, digit count already normalised to 1..8.
    typedef struct packed {
        logic [11:0] base;
        logic [6:0]  column;
        logic [31:0] value;
        logic [3:0]  digits;
    } FieldEntry;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } WriterState;

    WriterState state;
    WriterState nextState;

    FieldEntry  fifoMem [FIFO_DEPTH];
    logic [PTR_W:0] writePtr;
    logic [PTR_W:0] readPtr;
    logic       fifoEmpty;
    logic       fifoFull;
    FieldEntry  newEntry;
    FieldEntry  headEntry;

    logic       acceptFire;
    logic       rowInRange;
    logic       pushEn;
    logic       dropEn;
    logic       popEn;

    logic [11:0] workBase;
    logic [6:0]  workColumn;
    logic [31:0] workValue;
    logic [3:0]  workDigits;
    logic [2:0]  workIndex;

    logic [3:0]  charOffset;
    logic [7:0]  charColumn;
    logic [11:0] charAddress;
    logic [3:0]  nibble;
    logic [7:0]  hexChar;
    logic [7:0]  digitChar;
    logic        charOnScreen;

`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
    logic        seenNonzero;
`endif

    // Queue status; a full queue refuses new requests even if it pops this edge.
    assign fifoEmpty = (writePtr == readPtr);
    assign fifoFull  = (writePtr[PTR_W] != readPtr[PTR_W]) &&
                       (writePtr[PTR_W-1:0] == readPtr[PTR_W-1:0]);

    assign request.requestReady = !fifoFull;

    assign acceptFire = request.requestValid && request.requestReady;
    assign rowInRange = ({27'd0, request.requestRow} < 32'(ROWS));
    assign pushEn     = acceptFire && rowInRange;
    assign dropEn     = acceptFire && !rowInRange;

    assign busy = !fifoEmpty || (state != IDLE);

    // Resolve the request into a queue entry: linear address of the first digit
    // and a digit count where 0 and anything above 8 mean a full 32-bit value.
    always_comb begin
        newEntry        = '0;
        newEntry.base   = 12'(request.requestRow) * 12'(COLUMNS) + 12'(request.requestColumn);
        newEntry.column = request.requestColumn;
        newEntry.value  = request.requestValue;
        if ((request.requestDigits == 4'd0) || (request.requestDigits > 4'd8)) begin
            newEntry.digits = 4'd8;
        end else begin
            newEntry.digits = request.requestDigits;
        end
    end

    assign headEntry = fifoMem[readPtr[PTR_W-1:0]];

    // Queue storage carries no reset: only slots between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (pushEn) begin
            fifoMem[writePtr[PTR_W-1:0]] <= newEntry;
        end
    end

    // Queue pointers advance independently so a push and a pop can share an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            writePtr <= '0;
            readPtr  <= '0;
        end else begin
            if (pushEn) begin
                writePtr <= writePtr + 1'b1;
            end
            if (popEn) begin
                readPtr <= readPtr + 1'b1;
            end
        end
    end

    // Count off-screen requests, sticking at 255 instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            droppedCount <= 8'd0;
        end else if (dropEn && (droppedCount != 8'hFF)) begin
            droppedCount <= droppedCount + 8'd1;
        end
    end

    // State register for the field writer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and pop decision: the last digit of a field pops the next one
    // directly so consecutive fields print without a gap cycle.
    always_comb begin
        nextState = state;
        popEn     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    popEn     = 1'b1;
                    nextState = WRITE;
                end
            end
            WRITE: begin
                if (workIndex == 3'd0) begin
                    if (!fifoEmpty) begin
                        popEn = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Character currently being emitted: which nibble, where it lands, whether
    // it is still on the same screen row, and its ASCII code.
    always_comb begin
        charOffset   = workDigits - 4'd1 - {1'b0, workIndex};
        charColumn   = {1'b0, workColumn} + {4'd0, charOffset};
        charAddress  = workBase + {8'd0, charOffset};
        charOnScreen = ({24'd0, charColumn} < 32'(COLUMNS));
        nibble       = workValue[{workIndex, 2'b00} +: 4];
        if (nibble < 4'd10) begin
            hexChar = 8'h30 + {4'd0, nibble};
        end else begin
            hexChar = 8'h37 + {4'd0, nibble};
        end
        digitChar = hexChar;
`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
        if ((workIndex != 3'd0) && !seenNonzero && (nibble == 4'd0)) begin
            digitChar = 8'h20;
        end
`endif
    end

    // Working registers: load a popped field, otherwise step to the next digit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            workBase   <= 12'd0;
            workColumn <= 7'd0;
            workValue  <= 32'd0;
            workDigits <= 4'd1;
            workIndex  <= 3'd0;
        end else if (popEn) begin
            workBase   <= headEntry.base;
            workColumn <= headEntry.column;
            workValue  <= headEntry.value;
            workDigits <= headEntry.digits;
            workIndex  <= 3'(headEntry.digits - 4'd1);
        end else if (state == WRITE) begin
            workIndex  <= workIndex - 3'd1;
        end
    end

`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
    // Remember whether a nonzero digit has been printed in the current field.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seenNonzero <= 1'b0;
        end else if (popEn) begin
            seenNonzero <= 1'b0;
        end else if (state == WRITE) begin
            seenNonzero <= seenNonzero || (nibble != 4'd0);
        end
    end
`endif

    // Terminal write port is fully registered; idle cycles only drop the strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            terminalAddress     <= 12'd0;
            terminalWriteData   <= 8'd0;
            shouldWriteTerminal <= 1'b0;
        end else if (state == WRITE) begin
            terminalAddress     <= charAddress;
            terminalWriteData   <= digitChar;
            shouldWriteTerminal <= charOnScreen;
        end else begin
            shouldWriteTerminal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_terminal_hex_writer.sv
// Self-checking bench for terminal_hex_writer. A field-level model predicts, for
// every clock edge, which character is on the write port, plus busy, ready and
// the drop counter; a compare process checks the DUT each cycle and directed
// tests add hand-computed literal expectations.
module tb_terminal_hex_writer;

    localparam int COLUMNS    = 80;
    localparam int ROWS       = 30;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] terminalAddress;
    logic        shouldWriteTerminal;
    logic [7:0]  terminalWriteData;
    logic        busy;
    logic [7:0]  droppedCount;

    terminal_hex_writer_if busIf ();

    terminal_hex_writer #(
        .COLUMNS    (COLUMNS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .request             (busIf),
        .terminalAddress     (terminalAddress),
        .shouldWriteTerminal (shouldWriteTerminal),
        .terminalWriteData   (terminalWriteData),
        .busy                (busy),
        .droppedCount        (droppedCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        int accept;
        int start;
        int digits;
    } FieldRec;

    typedef struct {
        bit          strobe;
        logic [11:0] addr;
        logic [7:0]  data;
    } CharRec;

    FieldRec fields[$];
    CharRec  expectedChars[int];
    CharRec  expNow;
    int      cycle = 0;
    int      nextFree = 0;
    int      modelDropped = 0;
    int      lastAcceptCycle = -1;
    int      checks = 0;
    int      failures = 0;
    int      strobeCount = 0;
    int      firstStrobe = -1;
    int      lastStrobe = -1;

    // Compare one observed value against the required one.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cycle, actual, required);
        end
    endtask

    // Requests in the queue after edge t: accepted by then, not yet popped (pop is one edge before start).
    function automatic int occAfter(input int t);
        int n = 0;
        foreach (fields[i]) begin
            if (fields[i].accept <= t && t < fields[i].start - 1) n++;
        end
        return n;
    endfunction

    // Busy after edge t while a field is queued or still has a digit to register.
    function automatic bit busyAfter(input int t);
        foreach (fields[i]) begin
            if (fields[i].accept <= t && t <= fields[i].start + fields[i].digits - 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Lay out the characters of one field on the cycles it will occupy.
    function automatic void expandField(input int row, input int col, input logic [31:0] value,
                                        input int d, input int start);
        bit seen = 1'b0;
        for (int i = 0; i < d; i++) begin
            CharRec c;
            int nib;
            nib = int'((value >> (4 * (d - 1 - i))) & 32'hF);
            c.strobe = (col + i) < COLUMNS;
            c.addr   = 12'(row * COLUMNS + col + i);
            c.data   = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
            if (nib != 0) seen = 1'b1;
`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
            if (!seen && i != d - 1) c.data = 8'h20;
`endif
            expectedChars[start + i] = c;
        end
    endfunction

    // Model update on each rising edge: accept, drop or schedule a field.
    initial begin
        forever begin
            @(posedge clock);
            cycle++;
            if (reset && busIf.requestValid && (occAfter(cycle - 1) < FIFO_DEPTH)) begin
                lastAcceptCycle = cycle;
                if (int'(busIf.requestRow) >= ROWS) begin
                    if (modelDropped < 255) modelDropped++;
                end else begin
                    int d;
                    int start;
                    d = (busIf.requestDigits == 4'd0 || busIf.requestDigits > 4'd8) ? 8 : int'(busIf.requestDigits);
                    start = (cycle + 2 > nextFree) ? cycle + 2 : nextFree;
                    fields.push_back('{cycle, start, d});
                    expandField(int'(busIf.requestRow), int'(busIf.requestColumn), busIf.requestValue, d, start);
                    nextFree = start + d;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                checkOutput("resetStrobe", {31'd0, shouldWriteTerminal}, 32'd0);
                checkOutput("resetAddress", {20'd0, terminalAddress}, 32'd0);
                checkOutput("resetData", {24'd0, terminalWriteData}, 32'd0);
                checkOutput("resetBusy", {31'd0, busy}, 32'd0);
                checkOutput("resetDropped", {24'd0, droppedCount}, 32'd0);
            end else begin
                expNow = '{1'b0, 12'd0, 8'd0};
                if (expectedChars.exists(cycle)) expNow = expectedChars[cycle];
                checkOutput("strobe", {31'd0, shouldWriteTerminal}, {31'd0, expNow.strobe});
                if (expNow.strobe && shouldWriteTerminal) begin
                    checkOutput("address", {20'd0, terminalAddress}, {20'd0, expNow.addr});
                    checkOutput("data", {24'd0, terminalWriteData}, {24'd0, expNow.data});
                end
                if (shouldWriteTerminal) begin
                    strobeCount++;
                    if (firstStrobe < 0) firstStrobe = cycle;
                    lastStrobe = cycle;
                end
                checkOutput("busy", {31'd0, busy}, {31'd0, busyAfter(cycle)});
                checkOutput("ready", {31'd0, busIf.requestReady}, {31'd0, occAfter(cycle) < FIFO_DEPTH});
                checkOutput("dropped", {24'd0, droppedCount}, 32'(modelDropped));
            end
        end
    end

    // Offer one request and hold it until the writer takes it; valid stays high afterwards.
    task automatic applyStimulus(input int row, input int col, input logic [31:0] value, input int digits);
        bit taken = 1'b0;
        @(negedge clock);
        busIf.requestValid  = 1'b1;
        busIf.requestRow    = 5'(row);
        busIf.requestColumn = 7'(col);
        busIf.requestValue  = value;
        busIf.requestDigits = 4'(digits);
        for (int k = 0; k < 100 && !taken; k++) begin
            @(posedge clock);
            #1;
            if (lastAcceptCycle == cycle) taken = 1'b1;
        end
        if (!taken) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic releaseBus();
        @(negedge clock);
        busIf.requestValid = 1'b0;
    endtask

    // Land just after the negedge that follows edge 'target'.
    task automatic waitUntilCycle(input int target);
        bit reached = 1'b0;
        for (int k = 0; k < 500 && !reached; k++) begin
            @(negedge clock);
            if (cycle >= target) reached = 1'b1;
        end
        if (!reached) checkOutput("cycleTimeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clock);
            #1;
            if (!busy && !shouldWriteTerminal) idle = 1'b1;
        end
        if (!idle) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int s0;
        busIf.requestValid  = 1'b0;
        busIf.requestRow    = 5'd0;
        busIf.requestColumn = 7'd0;
        busIf.requestValue  = 32'd0;
        busIf.requestDigits = 4'd0;

        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #1 checkOutput("readyAfterReset", {31'd0, busIf.requestReady}, 32'd1);

        // 8-digit field at the top-left corner.
        applyStimulus(0, 0, 32'h0000ABCD, 8);
        n = lastAcceptCycle;
        releaseBus();
        waitUntilCycle(n + 2);
        checkOutput("firstStrobe", {31'd0, shouldWriteTerminal}, 32'd1);
        checkOutput("firstAddr", {20'd0, terminalAddress}, 32'd0);
        checkOutput("firstData", {24'd0, terminalWriteData}, 32'h30);
        waitUntilCycle(n + 6);
        checkOutput("fifthAddr", {20'd0, terminalAddress}, 32'd4);
        checkOutput("fifthData", {24'd0, terminalWriteData}, 32'h41);
        waitUntilCycle(n + 9);
        checkOutput("lastAddr", {20'd0, terminalAddress}, 32'd7);
        checkOutput("lastData", {24'd0, terminalWriteData}, 32'h44);
        waitUntilCycle(n + 10);
        checkOutput("afterFieldStrobe", {31'd0, shouldWriteTerminal}, 32'd0);
        checkOutput("afterFieldBusy", {31'd0, busy}, 32'd0);

        // Field running off the end of row 2: only columns 78 and 79 are written.
        s0 = strobeCount;
        applyStimulus(2, 78, 32'h00000012, 4);
        n = lastAcceptCycle;
        releaseBus();
        waitUntilCycle(n + 2);
        checkOutput("edgeAddr", {20'd0, terminalAddress}, 32'd238);
        checkOutput("edgeData", {24'd0, terminalWriteData}, 32'h30);
        waitUntilCycle(n + 4);
        checkOutput("edgeSuppressed", {31'd0, shouldWriteTerminal}, 32'd0);
        waitIdle();
        checkOutput("edgeWriteCount", 32'(strobeCount - s0), 32'd2);

        // Off-screen rows are dropped and counted, saturating at 255.
        s0 = strobeCount;
        applyStimulus(30, 5, 32'h1234, 3);
        releaseBus();
        repeat (3) @(negedge clock);
        #1 checkOutput("droppedOne", {24'd0, droppedCount}, 32'd1);
        checkOutput("droppedNoWrites", 32'(strobeCount - s0), 32'd0);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(30 + (i % 2), i % 80, 32'(i), 2);
        end
        releaseBus();
        repeat (2) @(negedge clock);
        #1 checkOutput("droppedSaturated", {24'd0, droppedCount}, 32'd255);

        // Back-pressure: a long field, then five requests with valid held high.
        s0 = strobeCount;
        firstStrobe = -1;
        applyStimulus(3, 0, 32'h89ABCDEF, 8);
        applyStimulus(4, 0, 32'h00000123, 3);
        applyStimulus(5, 10, 32'h000000FF, 2);
        applyStimulus(6, 20, 32'h0000C0DE, 4);
        applyStimulus(7, 0, 32'h00000009, 1);
        #1 checkOutput("readyWhenFull", {31'd0, busIf.requestReady}, 32'd0);
        applyStimulus(8, 0, 32'h12345678, 0);
        releaseBus();
        waitIdle();
        checkOutput("burstWriteCount", 32'(strobeCount - s0), 32'd26);
        checkOutput("burstNoGap", 32'(lastStrobe - firstStrobe + 1), 32'd26);

        // Reset during the third character of a field with another queued behind it.
        applyStimulus(1, 10, 32'h89ABCDEF, 8);
        n = lastAcceptCycle;
        applyStimulus(9, 0, 32'h00000005, 2);
        releaseBus();
        waitUntilCycle(n + 4);
        checkOutput("thirdCharAddr", {20'd0, terminalAddress}, 32'd92);
        checkOutput("thirdCharData", {24'd0, terminalWriteData}, 32'h41);
        #1;
        reset = 1'b0;
        fields.delete();
        expectedChars.delete();
        nextFree = 0;
        modelDropped = 0;
        #1;
        checkOutput("asyncResetStrobe", {31'd0, shouldWriteTerminal}, 32'd0);
        checkOutput("asyncResetAddr", {20'd0, terminalAddress}, 32'd0);
        checkOutput("asyncResetData", {24'd0, terminalWriteData}, 32'd0);
        checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        s0 = strobeCount;
        repeat (12) @(negedge clock);
        #1 checkOutput("postResetNoWrites", 32'(strobeCount - s0), 32'd0);
        checkOutput("postResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("postResetReady", {31'd0, busIf.requestReady}, 32'd1);

        // Leading zeros, a zero value and an oversized digit count.
        applyStimulus(10, 0, 32'h00000F00, 8);
        n = lastAcceptCycle;
        releaseBus();
        waitUntilCycle(n + 2);
`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
        checkOutput("leadingZeroData", {24'd0, terminalWriteData}, 32'h20);
`else
        checkOutput("leadingZeroData", {24'd0, terminalWriteData}, 32'h30);
`endif
        waitUntilCycle(n + 7);
        checkOutput("nonzeroDigitData", {24'd0, terminalWriteData}, 32'h46);
        checkOutput("nonzeroDigitAddr", {20'd0, terminalAddress}, 32'd805);
        waitIdle();

        applyStimulus(11, 0, 32'h00000000, 3);
        n = lastAcceptCycle;
        releaseBus();
        waitUntilCycle(n + 2);
`ifdef TERMINAL_HEX_WRITER_ZERO_SUPPRESS_EN
        checkOutput("zeroValueLead", {24'd0, terminalWriteData}, 32'h20);
`else
        checkOutput("zeroValueLead", {24'd0, terminalWriteData}, 32'h30);
`endif
        waitUntilCycle(n + 4);
        checkOutput("zeroValueLast", {24'd0, terminalWriteData}, 32'h30);
        waitIdle();

        applyStimulus(12, 0, 32'hDEADBEEF, 9);
        n = lastAcceptCycle;
        releaseBus();
        waitUntilCycle(n + 2);
        checkOutput("digitsNineAddr", {20'd0, terminalAddress}, 32'd960);
        checkOutput("digitsNineData", {24'd0, terminalWriteData}, 32'h44);
        waitIdle();

        repeat (3) @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
